axis_dominance_tracker: RTL and testbench

//  Parametrised dominant-axis detector for the MPU6050 accelerometer path. On each completed

---
 rtl/axis_dominance_tracker.sv | 199 +++++++++++++++++++
 tb/tb_axis_dominance_tracker.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_dominance_tracker.sv
// Purpose: picks the dominant accelerometer axis by |sample|, with hysteresis and stability filtering.
// Latency: outputs and RESCAN update NCH edges after the accept edge; RESCAN is high for exactly one cycle.
// Backpressure: TIC/COMPLETED are ignored while BUSY; the sample set is latched on accept.
module axis_dominance_tracker #(
    parameter int WIDTH  = 16,
    parameter int NCH    = 3,
    parameter int HYST   = 64,
    parameter int STABLE = 2,
    localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 MCLK,
    input  logic                 nRST,
    input  logic                 TIC,
    input  logic                 COMPLETED,
    input  logic [NCH*WIDTH-1:0] DATA,
    output logic                 RESCAN,
    output logic                 BUSY,
    output logic [NCH-1:0]       LED_N,
    output logic                 SIGN_N,
    output logic [IW-1:0]        DOM_IDX,
    output logic                 DOM_VALID
);

    // Stability counter only needs to reach STABLE.
    localparam int CW = (STABLE > 1) ? $clog2(STABLE + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DECIDE,
        S_ACK
    } state_t;

    // Absolute value as unsigned WIDTH bits; the most negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

    // Extracts channel c from a packed sample set (channel 0 in the LSBs).
    function automatic logic [WIDTH-1:0] chan(input logic [NCH*WIDTH-1:0] d, input logic [IW-1:0] c);
        return d[c*WIDTH +: WIDTH];
    endfunction

    state_t               state_q,     state_d;
    logic [NCH*WIDTH-1:0] data_q,      data_d;
    logic [IW-1:0]        idx_q,       idx_d;
    logic [IW-1:0]        best_q,      best_d;
    logic [WIDTH-1:0]     bestmag_q,   bestmag_d;
    logic [IW-1:0]        pend_q,      pend_d;
    logic [CW-1:0]        cnt_q,       cnt_d;
    logic [IW-1:0]        dom_idx_q,   dom_idx_d;
    logic                 dom_valid_q, dom_valid_d;
    logic [NCH-1:0]       led_n_q,     led_n_d;
    logic                 sign_n_q,    sign_n_d;
    logic                 rescan_q,    rescan_d;
    logic                 busy_q,      busy_d;

    logic [WIDTH-1:0]     scan_mag;
    logic [WIDTH-1:0]     dom_mag;
    logic [WIDTH:0]       dom_thresh;
    logic [IW-1:0]        win;
    logic [WIDTH-1:0]     dom_smp;

    assign scan_mag   = mag_of(chan(data_q, idx_q));
    assign dom_mag    = mag_of(chan(data_q, dom_idx_q));
    // One extra bit so the hysteresis threshold can never wrap.
    assign dom_thresh = {1'b0, dom_mag} + (WIDTH+1)'(HYST);

    // Next-state and datapath updates for the scan/decide sequencer.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        idx_d       = idx_q;
        best_d      = best_q;
        bestmag_d   = bestmag_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        dom_idx_d   = dom_idx_q;
        dom_valid_d = dom_valid_q;
        led_n_d     = led_n_q;
        sign_n_d    = sign_n_q;
        rescan_d    = rescan_q;
        busy_d      = busy_q;
        win         = best_q;
        dom_smp     = '0;

        case (state_q)
            S_IDLE: begin
                if (TIC && COMPLETED) begin
                    // Channel 0 seeds the running maximum; the scan starts at channel 1.
                    data_d    = DATA;
                    best_d    = '0;
                    bestmag_d = mag_of(DATA[WIDTH-1:0]);
                    idx_d     = IW'(1);
                    busy_d    = 1'b1;
                    state_d   = (NCH > 1) ? S_SCAN : S_DECIDE;
                end
            end

            S_SCAN: begin
                // Strict compare keeps the lowest index on ties.
                if (scan_mag > bestmag_q) begin
                    best_d    = idx_q;
                    bestmag_d = scan_mag;
                end
                if (idx_q == IW'(NCH - 1)) begin
                    state_d = S_DECIDE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end

            S_DECIDE: begin
                // A challenger must beat the committed channel by more than HYST.
                if (dom_valid_q && (best_q != dom_idx_q) && ({1'b0, bestmag_q} <= dom_thresh)) begin
                    win = dom_idx_q;
                end

                if (dom_valid_q && (win == dom_idx_q)) begin
                    cnt_d = '0;
                end else if (win == pend_q) begin
                    cnt_d = (cnt_q == CW'(STABLE)) ? cnt_q : cnt_q + CW'(1);
                end else begin
                    pend_d = win;
                    cnt_d  = CW'(1);
                end

                if (cnt_d == CW'(STABLE)) begin
                    dom_idx_d   = win;
                    dom_valid_d = 1'b1;
                    cnt_d       = '0;
                end

                // Display reflects the post-decision committed channel.
                dom_smp = chan(data_q, dom_idx_d);
                if (dom_valid_d) begin
                    led_n_d  = ~(NCH'(1) << dom_idx_d);
                    sign_n_d = ~dom_smp[WIDTH-1];
                end else begin
                    led_n_d  = '1;
                end

                rescan_d = 1'b1;
                state_d  = S_ACK;
            end

            S_ACK: begin
                rescan_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset aborts any scan in flight.
    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            idx_q       <= '0;
            best_q      <= '0;
            bestmag_q   <= '0;
            pend_q      <= '0;
            cnt_q       <= '0;
            dom_idx_q   <= '0;
            dom_valid_q <= 1'b0;
            led_n_q     <= '1;
            sign_n_q    <= 1'b1;
            rescan_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            best_q      <= best_d;
            bestmag_q   <= bestmag_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            dom_idx_q   <= dom_idx_d;
            dom_valid_q <= dom_valid_d;
            led_n_q     <= led_n_d;
            sign_n_q    <= sign_n_d;
            rescan_q    <= rescan_d;
            busy_q      <= busy_d;
        end
    end

    assign RESCAN    = rescan_q;
    assign BUSY      = busy_q;
    assign LED_N     = led_n_q;
    assign SIGN_N    = sign_n_q;
    assign DOM_IDX   = dom_idx_q;
    assign DOM_VALID = dom_valid_q;

endmodule

// File: tb/tb_axis_dominance_tracker.sv
// Purpose: randomized and directed checking of the dominant-axis tracker against a reference model.
// Latency: expects RESCAN NCH edges after accept, one cycle wide.
// Backpressure: holds TIC/COMPLETED high in one scenario to confirm requests are ignored while busy.
module tb_axis_dominance_tracker;

    localparam int HYST   = 64;
    localparam int STABLE = 2;

    logic        MCLK = 1'b0;
    logic        nRST;
    logic        TIC, COMPLETED;
    logic [47:0] DATA;
    logic        RESCAN, BUSY, SIGN_N, DOM_VALID;
    logic [2:0]  LED_N;
    logic [1:0]  DOM_IDX;

    logic        TIC1, COMPLETED1;
    logic [15:0] DATA1;
    logic        RESCAN1, BUSY1, SIGN_N1, DOM_VALID1;
    logic [0:0]  LED_N1;
    logic [0:0]  DOM_IDX1;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit m_valid;
    int m_idx, m_pend, m_cnt;
    bit m_sign;

    axis_dominance_tracker #(.WIDTH(16), .NCH(3), .HYST(HYST), .STABLE(STABLE)) dut (
        .MCLK(MCLK), .nRST(nRST), .TIC(TIC), .COMPLETED(COMPLETED), .DATA(DATA),
        .RESCAN(RESCAN), .BUSY(BUSY), .LED_N(LED_N), .SIGN_N(SIGN_N),
        .DOM_IDX(DOM_IDX), .DOM_VALID(DOM_VALID)
    );

    axis_dominance_tracker #(.WIDTH(16), .NCH(1), .HYST(HYST), .STABLE(STABLE)) dut1 (
        .MCLK(MCLK), .nRST(nRST), .TIC(TIC1), .COMPLETED(COMPLETED1), .DATA(DATA1),
        .RESCAN(RESCAN1), .BUSY(BUSY1), .LED_N(LED_N1), .SIGN_N(SIGN_N1),
        .DOM_IDX(DOM_IDX1), .DOM_VALID(DOM_VALID1)
    );

    always #5 MCLK = ~MCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_valid = 0; m_idx = 0; m_pend = 0; m_cnt = 0; m_sign = 1;
    endtask

    // Decision rules applied to one sample set, using plain integer arithmetic.
    task automatic model_step(input int x, input int y, input int z);
        int v[3];
        int mg[3];
        int w;
        v = '{x, y, z};
        foreach (v[i]) mg[i] = (v[i] < 0) ? -v[i] : v[i];
        w = 0;
        for (int i = 1; i < 3; i++) if (mg[i] > mg[w]) w = i;
        if (m_valid && w != m_idx && mg[w] <= mg[m_idx] + HYST) w = m_idx;
        if (m_valid && w == m_idx) m_cnt = 0;
        else if (w == m_pend) m_cnt = (m_cnt + 1 > STABLE) ? STABLE : m_cnt + 1;
        else begin m_pend = w; m_cnt = 1; end
        if (m_cnt >= STABLE) begin m_idx = w; m_valid = 1; m_cnt = 0; end
        if (m_valid) m_sign = (v[m_idx] < 0) ? 1'b0 : 1'b1;
    endtask

    function automatic logic [6:0] model_out();
        logic [2:0] l;
        l = m_valid ? ~(3'b001 << m_idx) : 3'b111;
        return {l, m_sign, 2'(m_idx), m_valid};
    endfunction

    task automatic do_reset();
        @(negedge MCLK);
        nRST = 0; TIC = 0; COMPLETED = 0; TIC1 = 0; COMPLETED1 = 0;
        @(negedge MCLK);
        @(negedge MCLK);
        nRST = 1;
        model_reset();
    endtask

    // Drives one accepted sample set, scrambles DATA after accept, and measures RESCAN timing.
    task automatic run_scan(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                            output int lat, output logic busy_mid, output logic resc_after,
                            output logic busy_after);
        @(negedge MCLK);
        DATA = {z, y, x}; TIC = 1; COMPLETED = 1;
        @(posedge MCLK);
        @(negedge MCLK);
        TIC = 0; COMPLETED = 0;
        DATA = {$urandom, $urandom};
        busy_mid = BUSY;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge MCLK);
            @(negedge MCLK);
            if (RESCAN === 1'b1) begin lat = k; break; end
        end
        @(posedge MCLK);
        @(negedge MCLK);
        resc_after = RESCAN;
        busy_after = BUSY;
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        @(negedge MCLK);
        nRST = 0; TIC = 0; COMPLETED = 0; TIC1 = 0; COMPLETED1 = 0; DATA = '0; DATA1 = '0;
        #1;
        obs = {LED_N, SIGN_N, RESCAN, BUSY, DOM_VALID, DOM_IDX};
        checks++;
        if (obs !== {3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00}) begin
            errors++; $display("FAIL reset_state got %b want %b", obs, {3'b111, 5'b10000, 1'b0});
        end
        obs = {4'b0, LED_N1, SIGN_N1, RESCAN1, BUSY1, DOM_VALID1};
        checks++;
        if (obs !== 9'b0_0001_1000) begin
            errors++; $display("FAIL reset_state_nch1 got %b want %b", obs, 9'b0_0001_1000);
        end
        @(negedge MCLK);
        nRST = 1;
        model_reset();
    endtask

    task automatic test_defaults();
        int lat; logic bm, ra, ba;
        do_reset();
        run_scan(16'sd1000, -16'sd200, 16'sd300, lat, bm, ra, ba);
        model_step(1000, -200, 300);
        checks++;
        if (lat !== 3 || bm !== 1'b1 || ra !== 1'b0 || ba !== 1'b0) begin
            errors++; $display("FAIL default_timing1 lat %0d busy %b rescan_after %b busy_after %b want 3 1 0 0", lat, bm, ra, ba);
        end
        checks++;
        if ({LED_N, SIGN_N, DOM_IDX, DOM_VALID} !== {3'b111, 1'b1, 2'd0, 1'b0}) begin
            errors++; $display("FAIL default_first got %b want 1111000", {LED_N, SIGN_N, DOM_IDX, DOM_VALID});
        end
        run_scan(16'sd1000, -16'sd200, 16'sd300, lat, bm, ra, ba);
        model_step(1000, -200, 300);
        checks++;
        if (lat !== 3 || ra !== 1'b0) begin
            errors++; $display("FAIL default_timing2 lat %0d rescan_after %b want 3 0", lat, ra);
        end
        checks++;
        if ({LED_N, SIGN_N, DOM_IDX, DOM_VALID} !== {3'b110, 1'b1, 2'd0, 1'b1}) begin
            errors++; $display("FAIL default_commit got %b want 1101001", {LED_N, SIGN_N, DOM_IDX, DOM_VALID});
        end
    endtask

    // Runs after test_defaults with channel 0 committed.
    task automatic test_hysteresis();
        int lat; logic bm, ra, ba;
        for (int i = 0; i < 2; i++) begin
            run_scan(16'sd1000, -16'sd1040, 16'sd0, lat, bm, ra, ba);
            model_step(1000, -1040, 0);
            checks++;
            if ({LED_N, SIGN_N, DOM_IDX, DOM_VALID} !== {3'b110, 1'b1, 2'd0, 1'b1}) begin
                errors++; $display("FAIL hyst_hold%0d got %b want 1101001", i, {LED_N, SIGN_N, DOM_IDX, DOM_VALID});
            end
        end
        run_scan(16'sd1000, -16'sd1100, 16'sd0, lat, bm, ra, ba);
        model_step(1000, -1100, 0);
        checks++;
        if ({LED_N, SIGN_N, DOM_IDX, DOM_VALID} !== {3'b110, 1'b1, 2'd0, 1'b1}) begin
            errors++; $display("FAIL hyst_pending got %b want 1101001", {LED_N, SIGN_N, DOM_IDX, DOM_VALID});
        end
        run_scan(16'sd1000, -16'sd1100, 16'sd0, lat, bm, ra, ba);
        model_step(1000, -1100, 0);
        checks++;
        if ({LED_N, SIGN_N, DOM_IDX, DOM_VALID} !== {3'b101, 1'b0, 2'd1, 1'b1}) begin
            errors++; $display("FAIL hyst_switch got %b want 1010011", {LED_N, SIGN_N, DOM_IDX, DOM_VALID});
        end
    endtask

    task automatic test_alternate();
        int lat; logic bm, ra, ba;
        int seen_valid;
        do_reset();
        seen_valid = 0;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) run_scan(16'sd0, 16'sd500, 16'sd100, lat, bm, ra, ba);
            else            run_scan(16'sd0, 16'sd100, 16'sd500, lat, bm, ra, ba);
            if (DOM_VALID !== 1'b0 || LED_N !== 3'b111) seen_valid++;
        end
        checks++;
        if (seen_valid !== 0) begin
            errors++; $display("FAIL alternate_no_commit got %0d committed decisions want 0", seen_valid);
        end
    endtask

    task automatic test_ties_extremes();
        int lat; logic bm, ra, ba;
        do_reset();
        repeat (2) run_scan(16'sd500, 16'sd500, 16'sd0, lat, bm, ra, ba);
        checks++;
        if ({LED_N, SIGN_N, DOM_IDX, DOM_VALID} !== {3'b110, 1'b1, 2'd0, 1'b1}) begin
            errors++; $display("FAIL tie_low_index got %b want 1101001", {LED_N, SIGN_N, DOM_IDX, DOM_VALID});
        end
        do_reset();
        repeat (2) run_scan(16'h7FFF, 16'h0000, 16'h8000, lat, bm, ra, ba);
        checks++;
        if ({LED_N, SIGN_N, DOM_IDX, DOM_VALID} !== {3'b011, 1'b0, 2'd2, 1'b1}) begin
            errors++; $display("FAIL extreme_neg got %b want 0110101", {LED_N, SIGN_N, DOM_IDX, DOM_VALID});
        end
    endtask

    // Strobes held high: accepts every NCH+2 edges, DATA changes every cycle.
    task automatic test_held();
        logic [47:0] cur;
        int bad_pulse, bad_out;
        do_reset();
        bad_pulse = 0; bad_out = 0;
        cur = '0;
        DATA = {$urandom, $urandom}; TIC = 1; COMPLETED = 1;
        for (int k = 0; k < 30; k++) begin
            if (k % 5 == 0) cur = DATA;
            @(posedge MCLK);
            @(negedge MCLK);
            if (RESCAN !== (k % 5 == 3)) bad_pulse++;
            if (k % 5 == 3) begin
                model_step(int'($signed(cur[15:0])), int'($signed(cur[31:16])), int'($signed(cur[47:32])));
                if ({LED_N, SIGN_N, DOM_IDX, DOM_VALID} !== model_out()) bad_out++;
            end
            DATA = {$urandom, $urandom};
            if (k % 3 == 0) DATA[15:0] = cur[15:0];
        end
        TIC = 0; COMPLETED = 0;
        checks++;
        if (bad_pulse !== 0) begin
            errors++; $display("FAIL held_rescan_pattern got %0d bad cycles want 0", bad_pulse);
        end
        checks++;
        if (bad_out !== 0) begin
            errors++; $display("FAIL held_outputs got %0d bad decisions want 0", bad_out);
        end
    endtask

    task automatic test_reset_midscan();
        int lat; logic bm, ra, ba;
        int pulses;
        logic [6:0] obs;
        do_reset();
        repeat (2) run_scan(16'sd1000, 16'sd0, 16'sd0, lat, bm, ra, ba);
        @(negedge MCLK);
        DATA = {16'sd0, 16'sd0, 16'sd2000}; TIC = 1; COMPLETED = 1;
        @(posedge MCLK);
        @(negedge MCLK);
        TIC = 0; COMPLETED = 0;
        @(posedge MCLK);
        @(negedge MCLK);
        nRST = 0;
        #1;
        obs = {LED_N, SIGN_N, RESCAN, BUSY, DOM_VALID};
        checks++;
        if (obs !== 7'b1111000) begin
            errors++; $display("FAIL midscan_reset got %b want 1111000", obs);
        end
        pulses = 0;
        @(negedge MCLK);
        nRST = 1;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge MCLK);
            if (RESCAN !== 1'b0 || BUSY !== 1'b0) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL midscan_no_rescan got %0d active cycles want 0", pulses);
        end
    endtask

    task automatic test_nch1();
        int lat;
        do_reset();
        for (int s = 0; s < 2; s++) begin
            @(negedge MCLK);
            DATA1 = -16'sd5; TIC1 = 1; COMPLETED1 = 1;
            @(posedge MCLK);
            @(negedge MCLK);
            TIC1 = 0; COMPLETED1 = 0; DATA1 = 16'h1234;
            lat = -1;
            for (int k = 1; k <= 6; k++) begin
                if (k == 1 && RESCAN1 === 1'b1) begin lat = 0; break; end
                @(posedge MCLK);
                @(negedge MCLK);
                if (RESCAN1 === 1'b1) begin lat = k; break; end
            end
            checks++;
            if (lat !== 1) begin
                errors++; $display("FAIL nch1_latency scan %0d got %0d want 1", s, lat);
            end
            @(negedge MCLK);
        end
        checks++;
        if ({LED_N1, SIGN_N1, DOM_IDX1, DOM_VALID1} !== 4'b0001) begin
            errors++; $display("FAIL nch1_commit got %b want 0001", {LED_N1, SIGN_N1, DOM_IDX1, DOM_VALID1});
        end
    endtask

    task automatic test_random();
        int lat; logic bm, ra, ba;
        int v[3];
        int dom, left;
        do_reset();
        dom = 0; left = 0;
        for (int n = 0; n < 40; n++) begin
            if (left == 0) begin dom = $urandom_range(0, 2); left = $urandom_range(1, 3); end
            left--;
            foreach (v[i]) v[i] = int'($urandom_range(0, 1200)) - 600;
            v[dom] = int'($urandom_range(0, 32768));
            if ($urandom_range(0, 1) == 1) v[dom] = -v[dom];
            if (v[dom] > 32767) v[dom] = 32767;
            run_scan(16'(v[0]), 16'(v[1]), 16'(v[2]), lat, bm, ra, ba);
            model_step(v[0], v[1], v[2]);
            checks++;
            if (lat !== 3 || ra !== 1'b0 || ba !== 1'b0) begin
                errors++; $display("FAIL rand_timing %0d lat %0d rescan_after %b busy_after %b want 3 0 0", n, lat, ra, ba);
            end
            checks++;
            if ({LED_N, SIGN_N, DOM_IDX, DOM_VALID} !== model_out()) begin
                errors++; $display("FAIL rand_out %0d got %b want %b", n, {LED_N, SIGN_N, DOM_IDX, DOM_VALID}, model_out());
            end
        end
    endtask

    initial begin
        nRST = 1; TIC = 0; COMPLETED = 0; DATA = '0;
        TIC1 = 0; COMPLETED1 = 0; DATA1 = '0;
        model_reset();
        test_reset();
        test_defaults();
        test_hysteresis();
        test_alternate();
        test_ties_extremes();
        test_held();
        test_reset_midscan();
        test_nch1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
